except_ctrl: RTL
================

EXCEPT_CTRL -- requirements
Module: except_ctrl

Interface
REQ-001 SHALL have parameter HANDLER_ADDR, default 32'h00000020, exception handler entry PC.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles flush_o stays high (legal 1..15).
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port inst_valid_i  in  1  a valid instruction occupies the MEM stage.
REQ-006 SHALL have port except_i  in  32  flags: bit8 syscall, bit9 invalid inst, bit10 trap, bit11 overflow, bit12 eret.
REQ-007 SHALL have port current_inst_addr_i  in  32  PC of the MEM-stage instruction.
REQ-008 SHALL have port is_in_delayslot_i  in  1  MEM-stage instruction is in a delay slot.
REQ-009 SHALL have ports cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 register values.
REQ-010 SHALL have ports wb_cp0_we_i (1), wb_cp0_waddr_i (5), wb_cp0_data_i (32)  in  CP0 write in flight in WB.
REQ-011 SHALL have port excepttype_o  out  32  exception code to CP0, one-cycle pulse.
REQ-012 SHALL have ports except_inst_addr_o (32), is_in_delayslot_o (1)  out  faulting PC and slot flag for CP0.
REQ-013 SHALL have ports flush_o (1), new_pc_o (32)  out  pipeline flush and redirect target.
REQ-014 SHALL have port busy_o  out  1  high in FLUSH state.

Function
REQ-015 SHALL form effective status/cause/epc by substituting wb_cp0_data_i when wb_cp0_we_i=1 and wb_cp0_waddr_i equals 12/13/14 respectively; cause bypass replaces only bits [9:8] and [23:22].
REQ-016 SHALL detect interrupt when (cause[15:8] & status[15:8]) != 0, status[0]=1, status[1]=0, all effective values.
REQ-017 SHALL evaluate detection only in IDLE with inst_valid_i=1; otherwise nothing is taken.
REQ-018 SHALL prioritise interrupt(0x1) > syscall(0x8) > invalid(0xa) > trap(0xd) > overflow(0xc) > eret(0xe); exactly one code issued.
REQ-019 SHALL take synchronous exceptions regardless of status[1]; only interrupts are masked by EXL.
REQ-020 SHALL, on the edge after detection: drive excepttype_o to the code for exactly one cycle, latch except_inst_addr_o and is_in_delayslot_o, assert flush_o, and enter FLUSH.
REQ-021 SHALL drive new_pc_o = effective epc (sampled at detection) for eret, else HANDLER_ADDR; held stable while flush_o=1.
REQ-022 SHALL implement FSM IDLE -> FLUSH on taken exception; FLUSH counts FLUSH_CYCLES cycles then -> IDLE; flush_o=busy_o=1 throughout FLUSH.
REQ-023 SHALL ignore except_i and inst_valid_i in FLUSH (flushed instructions); an exception present on the cycle FLUSH exits is not sampled until IDLE.
REQ-024 SHALL use a 4-bit down-counter loaded with FLUSH_CYCLES-1; FLUSH_CYCLES=1 gives a single flush cycle and back-to-back exceptions are then possible on the next IDLE cycle.
REQ-025 SHALL keep excepttype_o=0 in every cycle except the issue cycle.

Reset
REQ-026 SHALL, when rst=1 at any time including mid-FLUSH, immediately force IDLE, counter 0, and all outputs 0.
REQ-027 SHALL resume detection on the first rising edge after rst deasserts.

Verification
REQ-028 SHALL cover: status=32'h0000_0401, cause[10]=1, valid, PC=32'h100 -> next cycle excepttype_o=1, except_inst_addr_o=32'h100, new_pc_o=32'h20, flush_o high 2 cycles.
REQ-029 SHALL cover: syscall and overflow flags together, delay slot=1 -> excepttype_o=8 one cycle, is_in_delayslot_o=1.
REQ-030 SHALL cover: eret with cp0_epc_i=32'h200 while WB writes EPC=32'h300 -> new_pc_o=32'h300, excepttype_o=32'he.
REQ-031 SHALL cover: pending interrupt with status[1]=1 plus invalid flag -> excepttype_o=32'ha; pending interrupt alone with status[1]=1 -> no flush.
REQ-032 SHALL cover: second exception during FLUSH ignored; rst asserted in FLUSH cycle 1 -> flush_o, busy_o, new_pc_o 0 immediately.

Source files
------------

// File: rtl/except_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : except_ctrl
//  Purpose  : MEM-stage exception controller. Detects interrupts and
//             synchronous exceptions, issues a one-cycle exception code to
//             CP0, flushes the pipeline for FLUSH_CYCLES cycles and provides
//             the redirect PC (handler entry, or EPC for eret).
//  Ports    : clk, rst                      - clock, async active-high reset
//             inst_valid_i                  - valid instruction in MEM
//             except_i[31:0]                - exception flags (bits 8..12)
//             current_inst_addr_i[31:0]     - PC of MEM instruction
//             is_in_delayslot_i             - MEM instruction in delay slot
//             cp0_status_i/cause_i/epc_i    - current CP0 values
//             wb_cp0_we_i/waddr_i/data_i    - CP0 write in flight in WB
//             excepttype_o[31:0]            - exception code, one-cycle pulse
//             except_inst_addr_o[31:0]      - latched faulting PC
//             is_in_delayslot_o             - latched delay-slot flag
//             flush_o, busy_o               - high throughout FLUSH
//             new_pc_o[31:0]                - redirect target
//  Revision : 1.0 - initial release
// ============================================================================
module except_ctrl #(
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_0020,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_valid_i,
   input  logic [31:0] except_i,
   input  logic [31:0] current_inst_addr_i,
   input  logic        is_in_delayslot_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   input  logic        wb_cp0_we_i,
   input  logic [4:0]  wb_cp0_waddr_i,
   input  logic [31:0] wb_cp0_data_i,
   output logic [31:0] excepttype_o,
   output logic [31:0] except_inst_addr_o,
   output logic        is_in_delayslot_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        busy_o
);

   localparam logic [0:0]  ST_IDLE    = 1'b0;
   localparam logic [0:0]  ST_FLUSH   = 1'b1;
   localparam logic [3:0]  CNT_LOAD   = 4'(FLUSH_CYCLES - 1);

   localparam logic [31:0] CODE_INT   = 32'h0000_0001;
   localparam logic [31:0] CODE_SYS   = 32'h0000_0008;
   localparam logic [31:0] CODE_INV   = 32'h0000_000a;
   localparam logic [31:0] CODE_TRAP  = 32'h0000_000d;
   localparam logic [31:0] CODE_OV    = 32'h0000_000c;
   localparam logic [31:0] CODE_ERET  = 32'h0000_000e;

   logic [0:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] excepttype_q, excepttype_d;
   logic [31:0] addr_q, addr_d;
   logic        ds_q, ds_d;
   logic [31:0] new_pc_q, new_pc_d;

   logic [31:0] status_eff, cause_eff, epc_eff;
   logic        int_pending;
   logic [31:0] code;
   logic        take;

   // Forward a CP0 write still in WB so detection sees the newest values.
   // Only the software-writable cause bits (IP1:0 and IV/WP) are bypassed.
   always_comb begin
      status_eff = cp0_status_i;
      cause_eff  = cp0_cause_i;
      epc_eff    = cp0_epc_i;
      if (wb_cp0_we_i) begin
         if (wb_cp0_waddr_i == 5'd12) begin
            status_eff = wb_cp0_data_i;
         end
         if (wb_cp0_waddr_i == 5'd13) begin
            cause_eff[9:8]   = wb_cp0_data_i[9:8];
            cause_eff[23:22] = wb_cp0_data_i[23:22];
         end
         if (wb_cp0_waddr_i == 5'd14) begin
            epc_eff = wb_cp0_data_i;
         end
      end
   end

   // EXL (status[1]) masks interrupts only; synchronous exceptions still taken.
   assign int_pending = (|(cause_eff[15:8] & status_eff[15:8])) &&
                        status_eff[0] && !status_eff[1];

   always_comb begin
      code = '0;
      if (int_pending)      code = CODE_INT;
      else if (except_i[8])  code = CODE_SYS;
      else if (except_i[9])  code = CODE_INV;
      else if (except_i[10]) code = CODE_TRAP;
      else if (except_i[11]) code = CODE_OV;
      else if (except_i[12]) code = CODE_ERET;
   end

   assign take = (state_q == ST_IDLE) && inst_valid_i && (code != '0);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      excepttype_d = '0;          // code is a single-cycle pulse
      addr_d       = addr_q;
      ds_d         = ds_q;
      new_pc_d     = new_pc_q;
      case (state_q)
         ST_IDLE: begin
            if (take) begin
               state_d      = ST_FLUSH;
               cnt_d        = CNT_LOAD;
               excepttype_d = code;
               addr_d       = current_inst_addr_i;
               ds_d         = is_in_delayslot_i;
               new_pc_d     = (code == CODE_ERET) ? epc_eff : HANDLER_ADDR;
            end
         end
         default: begin
            // Instructions arriving here are being flushed; inputs ignored.
            if (cnt_q == 4'd0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         excepttype_q <= '0;
         addr_q       <= '0;
         ds_q         <= 1'b0;
         new_pc_q     <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         excepttype_q <= excepttype_d;
         addr_q       <= addr_d;
         ds_q         <= ds_d;
         new_pc_q     <= new_pc_d;
      end
   end

   assign excepttype_o       = excepttype_q;
   assign except_inst_addr_o = addr_q;
   assign is_in_delayslot_o  = ds_q;
   assign new_pc_o           = new_pc_q;
   assign flush_o            = (state_q == ST_FLUSH);
   assign busy_o             = (state_q == ST_FLUSH);

   logic w_unused_bits;
   assign w_unused_bits = ^{except_i[31:13], except_i[7:0],
                            status_eff[31:16], status_eff[7:2],
                            cause_eff[31:16], cause_eff[7:0]};

endmodule
`default_nettype wire
